axi_4_lite_master_ot: RTL and testbench

- Parametrised AXI4-Lite master with multiple outstanding transactions. Sits between the cache write-back/refill logic and the AXI4-Lite memory port.
- Generalises the single-beat bridge:
  - configurable data/address width and buffer depths;
  - decoupled AW/W channels;
  - client byte strobes;
  - credit-limited outstanding reads and writes;
  - sticky B/R response-error reporting.

---
 rtl/axi_4_lite_master_ot_if.sv | 37 +++
 rtl/axi_4_lite_master_ot.sv | 181 ++++++++++++++++++
 tb/tb_axi_4_lite_master_ot.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_4_lite_master_ot_if.sv
// rtl/axi_4_lite_master_ot_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_4_lite_master_ot_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_4_lite_master_ot.sv
// rtl/axi_4_lite_master_ot.sv - AXI4-Lite master, multiple outstanding; AXI_LITE_RAW_ORDER_EN holds reads behind writes
module axi_4_lite_master_ot #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         WB_DEPTH   = 4,
    parameter int         RD_DEPTH   = 4,
    parameter int         MAX_WR_OT  = 4,
    parameter int         MAX_RD_OT  = 4,
    parameter logic [2:0] PROT       = 3'b010
) (
    input  logic                      aclk_i,
    input  logic                      arstn_i,
    axi_4_lite_master_ot_if.master    axi,
    input  logic                      wb_valid_i,
    output logic                      wb_ready_o,
    input  logic [ADDR_WIDTH-1:0]     wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_strb_i,
    input  logic                      addr_req_i,
    output logic                      addr_ready_o,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [DATA_WIDTH-1:0]     mem_data_o,
    output logic                      mem_err_o,
    output logic                      wr_idle_o,
    output logic                      err_o,
    output logic [1:0]                err_resp_o,
    output logic                      err_is_wr_o,
    input  logic                      err_clr_i
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int WBA = $clog2(WB_DEPTH);
    localparam int RDA = $clog2(RD_DEPTH);
    localparam int RCW = RDA + 2;
    localparam logic [3:0]     WR_OT_MAX = 4'(MAX_WR_OT);
    localparam logic [RCW-1:0] RD_CAP    = RCW'(RD_DEPTH);
    localparam logic [RCW-1:0] RD_OT_MAX = RCW'(MAX_RD_OT);
    localparam logic [RCW-1:0] RD_ONE    = RCW'(1);
    localparam logic [WBA:0]   WB_ONE    = (WBA + 1)'(1);
    localparam logic [RDA:0]   RP_ONE    = (RDA + 1)'(1);

    // ---------------- write path ----------------
    logic [ADDR_WIDTH-1:0] aw_mem [WB_DEPTH];
    logic [DATA_WIDTH+SW-1:0] w_mem [WB_DEPTH];
    logic [WBA:0] aw_wp, aw_rp, w_wp, w_rp;
    logic [3:0]   wr_ot;
    logic aw_empty, aw_full, w_empty, w_full;
    logic wb_accept, aw_hs, w_hs, b_hs;

    assign aw_empty  = (aw_wp == aw_rp);
    assign aw_full   = (aw_wp[WBA] != aw_rp[WBA]) && (aw_wp[WBA-1:0] == aw_rp[WBA-1:0]);
    assign w_empty   = (w_wp == w_rp);
    assign w_full    = (w_wp[WBA] != w_rp[WBA]) && (w_wp[WBA-1:0] == w_rp[WBA-1:0]);

    assign wb_ready_o = !aw_full && !w_full && (wr_ot < WR_OT_MAX);
    assign wb_accept  = wb_valid_i && wb_ready_o;

    assign axi.awvalid = !aw_empty;
    assign axi.awaddr  = aw_mem[aw_rp[WBA-1:0]];
    assign axi.awprot  = PROT;
    assign axi.wvalid  = !w_empty;
    assign {axi.wdata, axi.wstrb} = w_mem[w_rp[WBA-1:0]];
    assign axi.bready  = (wr_ot != 4'd0);
    assign wr_idle_o   = (wr_ot == 4'd0);

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign b_hs  = axi.bvalid && axi.bready;

    always_ff @(posedge aclk_i) begin
        if (wb_accept) begin
            aw_mem[aw_wp[WBA-1:0]] <= wb_addr_i;
            w_mem[w_wp[WBA-1:0]]   <= {wb_data_i, wb_strb_i};
        end
    end

    // AW and W pop independently, so either channel may run ahead of the other.
    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            aw_wp <= '0;
            aw_rp <= '0;
            w_wp  <= '0;
            w_rp  <= '0;
            wr_ot <= '0;
        end else begin
            if (wb_accept) begin
                aw_wp <= aw_wp + WB_ONE;
                w_wp  <= w_wp + WB_ONE;
            end
            if (aw_hs) aw_rp <= aw_rp + WB_ONE;
            if (w_hs)  w_rp  <= w_rp + WB_ONE;
            if (wb_accept && !b_hs)
                wr_ot <= wr_ot + 4'd1;
            else if (!wb_accept && b_hs)
                wr_ot <= wr_ot - 4'd1;
        end
    end

    // ---------------- read path ----------------
    logic                  ar_full;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [RCW-1:0]        rd_ot, r_cnt, rd_issued, credit;
    logic [RDA:0]          r_wp, r_rp;
    logic [DATA_WIDTH:0]   r_mem [RD_DEPTH];
    logic rd_accept, ar_hs, r_hs, mem_pop, raw_ok;

`ifdef AXI_LITE_RAW_ORDER_EN
    assign raw_ok = (wr_ot == 4'd0);
`else
    assign raw_ok = 1'b1;
`endif

    // Every issued read holds a read-data FIFO slot, so R can always be accepted.
    assign r_cnt     = RCW'(r_wp - r_rp);
    assign rd_issued = rd_ot + RCW'(ar_full);
    assign credit    = rd_issued + r_cnt;

    assign addr_ready_o = (!ar_full || axi.arready) && (credit < RD_CAP)
                          && (rd_issued < RD_OT_MAX) && raw_ok;
    assign rd_accept    = addr_req_i && addr_ready_o;

    assign axi.arvalid = ar_full;
    assign axi.araddr  = ar_addr;
    assign axi.arprot  = PROT;
    assign axi.rready  = (rd_ot != '0);

    assign ar_hs   = axi.arvalid && axi.arready;
    assign r_hs    = axi.rvalid && axi.rready;
    assign mem_valid_o = (r_wp != r_rp);
    assign {mem_data_o, mem_err_o} = r_mem[r_rp[RDA-1:0]];
    assign mem_pop = mem_valid_o && mem_ready_i;

    always_ff @(posedge aclk_i) begin
        if (r_hs) r_mem[r_wp[RDA-1:0]] <= {axi.rdata, axi.rresp != 2'b00};
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ar_full <= 1'b0;
            ar_addr <= '0;
            rd_ot   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            if (rd_accept) begin
                ar_full <= 1'b1;
                ar_addr <= addr_i;
            end else if (ar_hs) begin
                ar_full <= 1'b0;
            end
            if (ar_hs && !r_hs)
                rd_ot <= rd_ot + RD_ONE;
            else if (!ar_hs && r_hs)
                rd_ot <= rd_ot - RD_ONE;
            if (r_hs)    r_wp <= r_wp + RP_ONE;
            if (mem_pop) r_rp <= r_rp + RP_ONE;
        end
    end

    // ---------------- sticky error capture (B beats R) ----------------
    logic b_err, r_err;
    assign b_err = b_hs && (axi.bresp != 2'b00);
    assign r_err = r_hs && (axi.rresp != 2'b00);

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_o       <= 1'b0;
            err_resp_o  <= 2'b00;
            err_is_wr_o <= 1'b0;
        end else if ((b_err || r_err) && (!err_o || err_clr_i)) begin
            err_o       <= 1'b1;
            err_resp_o  <= b_err ? axi.bresp : axi.rresp;
            err_is_wr_o <= b_err;
        end else if (err_clr_i) begin
            err_o       <= 1'b0;
            err_resp_o  <= 2'b00;
            err_is_wr_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_4_lite_master_ot.sv
// tb/tb_axi_4_lite_master_ot.sv - scoreboard bench for axi_4_lite_master_ot
module tb_axi_4_lite_master_ot;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wb_valid_i, wb_ready_o;
    logic [31:0] wb_addr_i, wb_data_i;
    logic [3:0]  wb_strb_i;
    logic        addr_req_i, addr_ready_o;
    logic [31:0] addr_i;
    logic        mem_valid_o, mem_ready_i, mem_err_o;
    logic [31:0] mem_data_o;
    logic        wr_idle_o, err_o, err_is_wr_o, err_clr_i;
    logic [1:0]  err_resp_o;

    axi_4_lite_master_ot_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_4_lite_master_ot dut (
        .aclk_i(clk), .arstn_i(rst_n), .axi(bus),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .wb_strb_i(wb_strb_i),
        .addr_req_i(addr_req_i), .addr_ready_o(addr_ready_o), .addr_i(addr_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_data_o(mem_data_o),
        .mem_err_o(mem_err_o), .wr_idle_o(wr_idle_o), .err_o(err_o),
        .err_resp_o(err_resp_o), .err_is_wr_o(err_is_wr_o), .err_clr_i(err_clr_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [32:0] exp_mem[$];
    int          b_due[$];
    logic [1:0]  b_rsp[$];
    int          r_due[$];
    logic [31:0] r_dat[$];
    logic [1:0]  r_rsp[$];

    int cyc = 0, aw_cnt = 0, w_cnt = 0, b_paired = 0, b_cnt = 0, mem_cnt = 0;
    int r_delay = 2;
    bit b_hs_f = 0, r_hs_f = 0;
    logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
    bit raw_watch = 0, raw_viol = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes seen at negedge commit on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.awvalid && bus.awready) begin
                    if (exp_aw.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got 0x%0h expected none", bus.awaddr);
                    end else check("aw_addr", bus.awaddr, exp_aw.pop_front());
                    aw_cnt++;
                end
                if (bus.wvalid && bus.wready) begin
                    if (exp_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got 0x%0h expected none", bus.wdata);
                    end else check("w_data_strb", {bus.wdata, bus.wstrb}, exp_w.pop_front());
                    w_cnt++;
                end
                if (bus.bvalid && bus.bready) b_hs_f = 1;
                if (bus.arvalid && bus.arready) begin
                    if (exp_ar.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: got 0x%0h expected none", bus.araddr);
                    end else check("ar_addr", bus.araddr, exp_ar.pop_front());
                    r_due.push_back(cyc + r_delay);
                    r_dat.push_back({16'hD000, bus.araddr[15:0]});
                    r_rsp.push_back(rresp_val);
                end
                if (bus.rvalid && bus.rready) r_hs_f = 1;
                if (mem_valid_o && mem_ready_i) begin
                    if (exp_mem.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_unexpected: got 0x%0h expected none", mem_data_o);
                    end else check("mem_data_err", {mem_data_o, mem_err_o}, exp_mem.pop_front());
                    mem_cnt++;
                end
                if (raw_watch && bus.arvalid && !wr_idle_o) raw_viol = 1;
            end
        end
    end

    // Slave responder: B two cycles after a paired AW+W, R r_delay cycles after AR.
    initial begin
        bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (b_hs_f) begin
                b_due.delete(0); b_rsp.delete(0); b_hs_f = 0; b_cnt++;
            end
            while (b_paired < aw_cnt && b_paired < w_cnt) begin
                b_due.push_back(cyc + 2); b_rsp.push_back(bresp_val); b_paired++;
            end
            bus.bvalid = (b_due.size() > 0) && (b_due[0] <= cyc);
            bus.bresp  = (b_rsp.size() > 0) ? b_rsp[0] : 2'b00;
            if (r_hs_f) begin
                r_due.delete(0); r_dat.delete(0); r_rsp.delete(0); r_hs_f = 0;
            end
            bus.rvalid = (r_due.size() > 0) && (r_due[0] <= cyc);
            bus.rdata  = (r_dat.size() > 0) ? r_dat[0] : 32'h0;
            bus.rresp  = (r_rsp.size() > 0) ? r_rsp[0] : 2'b00;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int waited);
        bit acc = 0;
        waited = 0;
        exp_aw.push_back(a);
        exp_w.push_back({d, s});
        wb_valid_i = 1; wb_addr_i = a; wb_data_i = d; wb_strb_i = s;
        while (!acc && waited < 200) begin
            acc = wb_ready_o;
            tick(1);
            waited++;
        end
        wb_valid_i = 0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL wb_accept_timeout: got no accept expected accept of 0x%0h", a);
        end
    endtask

    task automatic rd_req(input logic [31:0] a, input logic [31:0] d, input logic e);
        bit acc = 0;
        int n = 0;
        exp_ar.push_back(a);
        exp_mem.push_back({d, e});
        addr_req_i = 1; addr_i = a;
        while (!acc && n < 200) begin
            acc = addr_ready_o;
            tick(1);
            n++;
        end
        addr_req_i = 0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL rd_accept_timeout: got no accept expected accept of 0x%0h", a);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!wr_idle_o && n < 300) begin tick(1); n++; end
        check(name, wr_idle_o, 1);
    endtask

    task automatic wait_mem_drain(input string name);
        int n = 0;
        while (exp_mem.size() != 0 && n < 300) begin tick(1); n++; end
        check(name, exp_mem.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w, wsum, aw0, b0, m0;
        rst_n = 0; wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0; wb_strb_i = 0;
        addr_req_i = 0; addr_i = 0; mem_ready_i = 1; err_clr_i = 0;
        bus.awready = 1; bus.wready = 1; bus.arready = 1;
        tick(3);
        rst_n = 1;
        tick(1);

        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_wb_ready", wb_ready_o, 1);
        check("rst_addr_ready", addr_ready_o, 1);
        check("rst_wr_idle", wr_idle_o, 1);
        check("rst_err", {err_o, err_resp_o, err_is_wr_o}, 0);
        check("awprot", bus.awprot, 3'b010);
        check("arprot", bus.arprot, 3'b010);

        // Write burst: four back-to-back accepts, then credit exhausted.
        b0 = b_cnt; wsum = 0;
        for (int i = 0; i < 4; i++) begin
            wb_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, w);
            wsum += w;
        end
        check("burst_no_stall_cycles", wsum, 4);
        check("burst_wb_ready_at_4_ot", wb_ready_o, 0);
        check("burst_not_idle", wr_idle_o, 0);
        wait_idle("burst_idle");
        tick(1);
        check("burst_b_count", b_cnt - b0, 4);

        // Decoupled channels: AW drains while W is stalled.
        bus.wready = 0;
        aw0 = aw_cnt;
        wb_write(32'h110, 32'hA0, 4'h3, w);
        wb_write(32'h114, 32'hA1, 4'hC, w);
        wb_write(32'h118, 32'hA2, 4'hF, w);
        tick(3);
        check("dec_aw_beats", aw_cnt - aw0, 3);
        check("dec_wvalid", bus.wvalid, 1);
        check("dec_w_head", {bus.wdata, bus.wstrb}, {32'hA0, 4'h3});
        tick(1);
        check("dec_w_head_stable", {bus.wdata, bus.wstrb}, {32'hA0, 4'h3});
        check("dec_w_pending", exp_w.size(), 3);
        bus.wready = 1;
        wait_idle("dec_idle");

        // Read credit: R delayed, client not draining.
        r_delay = 10; mem_ready_i = 0; m0 = mem_cnt;
        rd_req(32'h300, 32'hD000_0300, 0);
        rd_req(32'h304, 32'hD000_0304, 0);
        rd_req(32'h308, 32'hD000_0308, 0);
        rd_req(32'h30C, 32'hD000_030C, 0);
        check("rd_credit_stop", addr_ready_o, 0);
        tick(15);
        check("rd_credit_hold", addr_ready_o, 0);
        check("rd_head_valid", mem_valid_o, 1);
        check("rd_head_data", mem_data_o, 32'hD000_0300);
        mem_ready_i = 1;
        rd_req(32'h310, 32'hD000_0310, 0);
        rd_req(32'h314, 32'hD000_0314, 0);
        wait_mem_drain("rd_drain");
        check("rd_beats", mem_cnt - m0, 6);
        check("rd_r_pending", r_due.size(), 0);
        r_delay = 2;

        // Errors: write error captured, later read error ignored.
        bresp_val = 2'b10;
        wb_write(32'h180, 32'h55, 4'hF, w);
        wait_idle("err_wr_idle");
        bresp_val = 2'b00;
        rresp_val = 2'b11;
        rd_req(32'h400, 32'hD000_0400, 1);
        wait_mem_drain("err_rd_drain");
        rresp_val = 2'b00;
        tick(1);
        check("err_o_set", err_o, 1);
        check("err_resp_first", err_resp_o, 2'b10);
        check("err_is_wr", err_is_wr_o, 1);
        err_clr_i = 1;
        tick(1);
        err_clr_i = 0;
        check("err_cleared", {err_o, err_resp_o, err_is_wr_o}, 0);

        // Reset mid-operation: two writes buffered, one read held in AR.
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        wb_write(32'h500, 32'h11, 4'hF, w);
        wb_write(32'h504, 32'h22, 4'hF, w);
        rd_req(32'h600, 32'hD000_0600, 0);
        check("pre_rst_arvalid", bus.arvalid, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_awvalid", bus.awvalid, 0);
        check("mid_rst_wvalid", bus.wvalid, 0);
        check("mid_rst_arvalid", bus.arvalid, 0);
        check("mid_rst_mem_valid", mem_valid_o, 0);
        check("mid_rst_wr_idle", wr_idle_o, 1);
        check("mid_rst_addr_ready", addr_ready_o, 1);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_mem.delete();
        b_due.delete(); b_rsp.delete(); r_due.delete(); r_dat.delete(); r_rsp.delete();
        aw_cnt = 0; w_cnt = 0; b_paired = 0; b_hs_f = 0; r_hs_f = 0;
        bus.awready = 1; bus.wready = 1; bus.arready = 1;
        @(posedge clk); #1;
        tick(1);
        rst_n = 1;
        tick(1);
        wb_write(32'h700, 32'hBEEF, 4'hF, w);
        rd_req(32'h704, 32'hD000_0704, 0);
        wait_idle("post_rst_idle");
        wait_mem_drain("post_rst_drain");

`ifdef AXI_LITE_RAW_ORDER_EN
        raw_viol = 0; raw_watch = 1;
        wb_write(32'h200, 32'h1234, 4'hF, w);
        rd_req(32'h200, 32'hD000_0200, 0);
        wait_mem_drain("raw_drain");
        raw_watch = 0;
        check("raw_ar_after_b", raw_viol, 0);
`else
        bus.wready = 0;
        wb_write(32'h200, 32'h1234, 4'hF, w);
        rd_req(32'h200, 32'hD000_0200, 0);
        wait_mem_drain("indep_rd_drain");
        check("indep_write_still_pending", wr_idle_o, 0);
        bus.wready = 1;
        wait_idle("indep_idle");
`endif

        tick(5);
        check("end_aw_queue", exp_aw.size(), 0);
        check("end_w_queue", exp_w.size(), 0);
        check("end_ar_queue", exp_ar.size(), 0);
        check("end_b_pending", b_due.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
